// File: rtl/im_arbiter.sv
// im_arbiter: shares the single-ported instruction memory between the fetch
// port (F) and the loader/debug port (L). Translates byte addresses into word
// addresses, flags out-of-range/misaligned accesses, arbitrates with fixed
// fetch priority plus loader starvation protection, and supports loader
// burst locking.
module im_arbiter #(
  parameter logic [31:0] BASE         = 32'h0000_3000,
  parameter int unsigned AW           = 12,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  // fetch side
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  // loader / debug side
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          l_err,
  // memory macro
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic {
    ST_ARB,
    ST_LOCK
  } state_t;

  // Byte span covered by the memory; one extra bit so AW up to 30 fits.
  localparam logic [32:0] SPAN  = 33'd1 << (AW + 2);
  localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  scnt_q, scnt_d;

  // Response pipeline: one access in flight, owner decides which port sees it.
  logic        rsp_valid_q;
  logic        rsp_owner_q;   // 1: loader issued the access
  logic        rsp_err_q;
  logic        rsp_rd_q;      // legal read: data comes from the memory

  logic        starved;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic [31:0] off;
  logic        legal;

  assign starved = (scnt_q == LIMIT);
  assign any_gnt = f_gnt | l_gnt;

  // Grant decision: LOCK serves only the loader; ARB prefers fetch unless the
  // loader has been starved up to the limit. No grants while in reset.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (state_q == ST_LOCK) begin
        l_gnt = l_req;
      end else if (l_req && (starved || !f_req)) begin
        l_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
      end
    end
  end

  // Address translation and legality of the granted access.
  always_comb begin
    sel_addr = l_gnt ? l_addr : f_addr;
    off      = sel_addr - BASE;
    legal    = (sel_addr[1:0] == 2'b00) && ({1'b0, off} < SPAN);
  end

  assign mem_en    = any_gnt & legal;
  assign mem_we    = mem_en & l_gnt & l_we;
  assign mem_addr  = off[AW+1:2];
  assign mem_wdata = l_wdata;

  // Next-state logic for the lock FSM and the starvation counter.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      ST_ARB:  if (l_gnt && l_lock) state_d = ST_LOCK;
      ST_LOCK: if (!l_lock)         state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
    if (l_gnt) begin
      scnt_d = '0;
    end else if (l_req && (scnt_q < LIMIT)) begin
      scnt_d = scnt_q + 4'd1;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ARB;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  // Capture the attributes of the granted access for its response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      rsp_valid_q <= any_gnt;
      rsp_owner_q <= l_gnt;
      rsp_err_q   <= any_gnt & ~legal;
      rsp_rd_q    <= any_gnt & legal & ~(l_gnt & l_we);
    end
  end

  // Steer the response to its owner; data is zero for errors and write acks.
  always_comb begin
    f_rvalid = rsp_valid_q & ~rsp_owner_q;
    l_rvalid = rsp_valid_q &  rsp_owner_q;
    f_err    = f_rvalid & rsp_err_q;
    l_err    = l_rvalid & rsp_err_q;
    f_rdata  = (f_rvalid && rsp_rd_q) ? mem_rdata : '0;
    l_rdata  = (l_rvalid && rsp_rd_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_im_arbiter.sv
// Testbench for im_arbiter: directed stimulus, a memory macro model, and a
// spec-level reference model checked against the DUT on every falling edge.
module tb_im_arbiter;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_gnt, f_rvalid, f_err;
  logic [31:0] f_rdata;
  logic        l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic        l_gnt, l_rvalid, l_err;
  logic [31:0] l_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  im_arbiter #(.BASE(BASE), .AW(12), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .l_err(l_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro: synchronous, data valid the cycle after mem_en.
  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] ref_mem [4096];
  bit          m_lock = 0;
  int          m_scnt = 0;
  bit          p_valid = 0, p_l = 0, p_err = 0;
  logic [31:0] p_data = '0;
  bit          e_f, e_l, e_legal;
  logic [31:0] e_addr, e_off;

  // Compare process: outputs vs. the model, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
      chk("rst_l_gnt", {31'd0, l_gnt}, 32'd0);
      chk("rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
      chk("rst_l_rvalid", {31'd0, l_rvalid}, 32'd0);
      chk("rst_errs", {30'd0, f_err, l_err}, 32'd0);
      chk("rst_f_rdata", f_rdata, 32'd0);
      chk("rst_l_rdata", l_rdata, 32'd0);
      chk("rst_mem", {30'd0, mem_en, mem_we}, 32'd0);
      m_lock = 0; m_scnt = 0; p_valid = 0;
    end else begin
      chk("f_rvalid", {31'd0, f_rvalid}, {31'd0, p_valid && !p_l});
      chk("l_rvalid", {31'd0, l_rvalid}, {31'd0, p_valid && p_l});
      if (p_valid && !p_l) begin
        chk("f_err", {31'd0, f_err}, {31'd0, p_err});
        chk("f_rdata", f_rdata, p_data);
      end
      if (p_valid && p_l) begin
        chk("l_err", {31'd0, l_err}, {31'd0, p_err});
        chk("l_rdata", l_rdata, p_data);
      end
      e_f = 0; e_l = 0;
      if (m_lock) e_l = l_req;
      else if (l_req && (m_scnt == 4 || !f_req)) e_l = 1;
      else e_f = f_req;
      e_addr  = e_l ? l_addr : f_addr;
      e_off   = e_addr - BASE;
      e_legal = (e_addr % 4 == 0) && (e_off < 32'd16384);
      chk("f_gnt", {31'd0, f_gnt}, {31'd0, e_f});
      chk("l_gnt", {31'd0, l_gnt}, {31'd0, e_l});
      chk("mem_en", {31'd0, mem_en}, {31'd0, (e_f || e_l) && e_legal});
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_l && l_we && e_legal});
      if ((e_f || e_l) && e_legal) chk("mem_addr", {20'd0, mem_addr}, e_off >> 2);
      if (e_l && l_we && e_legal) chk("mem_wdata", mem_wdata, l_wdata);
      // advance
      p_valid = e_f || e_l;
      p_l     = e_l;
      p_err   = !e_legal;
      if (!e_legal || (e_l && l_we)) p_data = '0;
      else p_data = ref_mem[e_off >> 2];
      if (e_l && l_we && e_legal) ref_mem[e_off >> 2] = l_wdata;
      if (e_l) m_scnt = 0;
      else if (l_req && m_scnt < 4) m_scnt++;
      if (!m_lock) m_lock = e_l && l_lock;
      else m_lock = l_lock;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  logic [31:0] ill_addr [4];
  bit          ill_ok   [4];
  logic [31:0] ill_data [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'hA000_0000 | i;
      ref_mem[i] = 32'hA000_0000 | i;
    end
    repeat (3) step();
    rst = 1'b0;

    // Reset mid-read
    step(); f_req = 1; f_addr = 32'h3004;
    mid();  chk("t1_gnt", {31'd0, f_gnt}, 32'd1);
    step(); f_req = 0; rst = 1;
    #1;
    chk("t1_rv_now", {31'd0, f_rvalid}, 32'd0);
    chk("t1_mem_now", {30'd0, mem_en, mem_we}, 32'd0);
    chk("t1_rdata_now", f_rdata, 32'd0);
    mid();  chk("t1_rv_mid", {31'd0, f_rvalid}, 32'd0);
    step(); rst = 0;
    step(); f_req = 1; f_addr = 32'h3000;
    mid();  chk("t1_gnt2", {31'd0, f_gnt}, 32'd1);
    step(); f_req = 0;
    mid();  chk("t1_rv2", {31'd0, f_rvalid}, 32'd1);
            chk("t1_word0", f_rdata, 32'hA000_0000);

    // Contention / starvation
    step(); f_req = 1; f_addr = 32'h3000; l_req = 1; l_we = 0; l_addr = 32'h3008;
    for (int i = 0; i < 9; i++) begin
      mid();
      chk("t2_l_gnt", {31'd0, l_gnt}, (i == 4) ? 32'd1 : 32'd0);
      chk("t2_f_gnt", {31'd0, f_gnt}, (i == 4) ? 32'd0 : 32'd1);
      chk("t2_l_rvalid", {31'd0, l_rvalid}, (i == 5) ? 32'd1 : 32'd0);
      if (i == 5) chk("t2_l_rdata", l_rdata, 32'hA000_0002);
      step();
    end
    f_req = 0; l_req = 0;

    // Lock burst
    step();
    l_req = 1; l_we = 1;
    for (int i = 0; i < 8; i++) begin
      l_addr  = 32'h3000 + 4 * i;
      l_wdata = 32'hDEAD_0000 + i;
      l_lock  = (i != 7);
      if (i == 1) begin f_req = 1; f_addr = 32'h3000; end
      mid();
      chk("t3_l_gnt", {31'd0, l_gnt}, 32'd1);
      chk("t3_f_gnt", {31'd0, f_gnt}, 32'd0);
      step();
    end
    l_req = 0; l_we = 0; l_lock = 0;
    mid();  chk("t3_f_after", {31'd0, f_gnt}, 32'd1);
    step(); f_req = 0;
    mid();  chk("t3_rd", f_rdata, 32'hDEAD_0000);

    // Illegal addresses and the last legal word
    ill_addr[0] = 32'h2FFC; ill_ok[0] = 0; ill_data[0] = 32'h0;
    ill_addr[1] = 32'h3002; ill_ok[1] = 0; ill_data[1] = 32'h0;
    ill_addr[2] = 32'h7000; ill_ok[2] = 0; ill_data[2] = 32'h0;
    ill_addr[3] = 32'h6FFC; ill_ok[3] = 1; ill_data[3] = 32'hA000_0FFF;
    for (int i = 0; i < 4; i++) begin
      step(); f_req = 1; f_addr = ill_addr[i];
      mid();
      chk("t4_gnt", {31'd0, f_gnt}, 32'd1);
      chk("t4_mem_en", {31'd0, mem_en}, {31'd0, ill_ok[i]});
      step(); f_req = 0;
      mid();
      chk("t4_rv", {31'd0, f_rvalid}, 32'd1);
      chk("t4_err", {31'd0, f_err}, {31'd0, !ill_ok[i]});
      chk("t4_data", f_rdata, ill_data[i]);
    end

    // Write ack, read-back, illegal write
    step(); l_req = 1; l_we = 1; l_addr = 32'h3010; l_wdata = 32'h1234_5678;
    mid();  chk("t5_wgnt", {31'd0, l_gnt}, 32'd1);
    step(); l_we = 0;
    mid();  chk("t5_ack", {31'd0, l_rvalid}, 32'd1);
            chk("t5_ack_data", l_rdata, 32'd0);
            chk("t5_ack_err", {31'd0, l_err}, 32'd0);
    step(); l_req = 0;
    mid();  chk("t5_rd", l_rdata, 32'h1234_5678);
            chk("t5_rd_err", {31'd0, l_err}, 32'd0);
    step(); l_req = 1; l_we = 1; l_addr = 32'h7000; l_wdata = 32'hFFFF_FFFF;
    mid();  chk("t5_ill_en", {30'd0, mem_en, mem_we}, 32'd0);
    step(); l_req = 0; l_we = 0;
    mid();  chk("t5_ill_err", {31'd0, l_err}, 32'd1);
            chk("t5_ill_data", l_rdata, 32'd0);

    // Pipelined fetch
    step();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin f_req = 1; f_addr = 32'h3000 + 4 * i; end
      else f_req = 0;
      mid();
      if (i > 0 && i < 4) begin
        chk("t6_rv", {31'd0, f_rvalid}, 32'd1);
        chk("t6_data", f_rdata, 32'hDEAD_0000 + i - 1);
      end
      if (i == 4) chk("t6_rv_end", {31'd0, f_rvalid}, 32'd0);
      step();
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
